// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcode map, ALU operation codes and FSM state codes.
package cpu_pkg;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_XOR   = 4'h4;
   localparam logic [3:0] OP_ADDI  = 4'h5;
   localparam logic [3:0] OP_LOAD  = 4'h6;
   localparam logic [3:0] OP_STORE = 4'h7;
   localparam logic [3:0] OP_BEQ   = 4'h8;
   localparam logic [3:0] OP_JMP   = 4'h9;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [2:0] ALU_ADD    = 3'd0;
   localparam logic [2:0] ALU_SUB    = 3'd1;
   localparam logic [2:0] ALU_AND    = 3'd2;
   localparam logic [2:0] ALU_OR     = 3'd3;
   localparam logic [2:0] ALU_XOR    = 3'd4;
   localparam logic [2:0] ALU_PASS_B = 3'd5;

   typedef logic [2:0] state_t;
   localparam state_t ST_FETCH  = 3'd0;
   localparam state_t ST_DECODE = 3'd1;
   localparam state_t ST_EXEC   = 3'd2;
   localparam state_t ST_MEM    = 3'd3;
   localparam state_t ST_WB     = 3'd4;
   localparam state_t ST_HALT   = 3'd5;

   // Codes A..E are reserved and retire straight from DECODE.
   function automatic logic is_nop_op(input logic [3:0] op);
      return (op >= 4'hA) && (op <= 4'hE);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode lookup feeding the control FSM's EXEC/MEM/WB decisions.
module ctrl_decode
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output logic [2:0] alu_op,
   output logic       alu_src_imm,
   output logic       is_mem,
   output logic       is_store,
   output logic       is_branch,
   output logic       is_jmp,
   output logic       writes_rd
);

   always_comb begin
      alu_op      = ALU_ADD;
      alu_src_imm = 1'b0;
      is_mem      = 1'b0;
      is_store    = 1'b0;
      is_branch   = 1'b0;
      is_jmp      = 1'b0;
      writes_rd   = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            alu_op    = opcode[2:0];
            writes_rd = 1'b1;
         end
         OP_ADDI: begin
            alu_src_imm = 1'b1;
            writes_rd   = 1'b1;
         end
         OP_LOAD: begin
            alu_src_imm = 1'b1;
            is_mem      = 1'b1;
            writes_rd   = 1'b1;
         end
         OP_STORE: begin
            alu_src_imm = 1'b1;
            is_mem      = 1'b1;
            is_store    = 1'b1;
         end
         OP_BEQ: begin
            alu_op    = ALU_SUB;
            is_branch = 1'b1;
         end
         OP_JMP: begin
            alu_op      = ALU_PASS_B;
            alu_src_imm = 1'b1;
            is_jmp      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ir_control_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/write-back sequencing
// with a memory-wait timeout that parks the machine in HALT with a sticky fault.
module ir_control_fsm
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       ir_ena,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       addr_sel,
   output logic       mem_req,
   output logic       mem_we,
   output logic [2:0] alu_op,
   output logic       alu_src_imm,
   output logic       rf_we,
   output logic       wb_sel,
   output logic       halted,
   output logic       fault
);

   // Fault fires on the wait cycle in which the count would reach MEM_TIMEOUT.
   localparam logic [3:0] WAIT_LIMIT = 4'(MEM_TIMEOUT - 1);

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg, cnt_next;
   logic       fault_reg, fault_next;
   logic       waiting;

   logic [2:0] dec_alu_op;
   logic       dec_imm, dec_mem, dec_store, dec_branch, dec_jmp, dec_wr;

   logic       ir_ena_c, pc_inc_c, pc_load_c, addr_sel_c, mem_req_c, mem_we_c;
   logic [2:0] alu_op_c;
   logic       alu_src_imm_c, rf_we_c, wb_sel_c, halted_c;

   ctrl_decode u_decode (
      .opcode      (opcode),
      .alu_op      (dec_alu_op),
      .alu_src_imm (dec_imm),
      .is_mem      (dec_mem),
      .is_store    (dec_store),
      .is_branch   (dec_branch),
      .is_jmp      (dec_jmp),
      .writes_rd   (dec_wr)
   );

   always_comb begin
      state_next    = state_reg;
      fault_next    = fault_reg;
      waiting       = 1'b0;
      ir_ena_c      = 1'b0;
      pc_inc_c      = 1'b0;
      pc_load_c     = 1'b0;
      addr_sel_c    = 1'b0;
      mem_req_c     = 1'b0;
      mem_we_c      = 1'b0;
      alu_op_c      = ALU_ADD;
      alu_src_imm_c = 1'b0;
      rf_we_c       = 1'b0;
      wb_sel_c      = 1'b0;
      halted_c      = 1'b0;
      case (state_reg)
         ST_FETCH: begin
            mem_req_c = 1'b1;
            if (mem_ready) begin
               ir_ena_c   = 1'b1;
               pc_inc_c   = 1'b1;
               state_next = ST_DECODE;
            end else begin
               waiting = 1'b1;
            end
         end
         ST_DECODE: begin
            if (opcode == OP_HALT)       state_next = ST_HALT;
            else if (is_nop_op(opcode))  state_next = ST_FETCH;
            else                         state_next = ST_EXEC;
         end
         ST_EXEC: begin
            alu_op_c      = dec_alu_op;
            alu_src_imm_c = dec_imm;
            if (dec_branch) begin
               pc_load_c  = alu_zero;
               state_next = ST_FETCH;
            end else if (dec_jmp) begin
               pc_load_c  = 1'b1;
               state_next = ST_FETCH;
            end else if (dec_mem) begin
               state_next = ST_MEM;
            end else if (dec_wr) begin
               state_next = ST_WB;
            end else begin
               state_next = ST_FETCH;
            end
         end
         ST_MEM: begin
            mem_req_c  = 1'b1;
            addr_sel_c = 1'b1;
            mem_we_c   = dec_store;
            if (mem_ready) state_next = dec_store ? ST_FETCH : ST_WB;
            else           waiting    = 1'b1;
         end
         ST_WB: begin
            rf_we_c    = 1'b1;
            wb_sel_c   = dec_mem && !dec_store;
            state_next = ST_FETCH;
         end
         ST_HALT: halted_c = 1'b1;
         default: state_next = ST_FETCH;
      endcase

      // A completing transfer on the limit cycle never reaches here (waiting=0).
      if (waiting && (cnt_reg == WAIT_LIMIT)) begin
         fault_next = 1'b1;
         state_next = ST_HALT;
      end

      if (state_next != state_reg) cnt_next = 4'd0;
      else if (waiting)            cnt_next = cnt_reg + 4'd1;
      else                         cnt_next = cnt_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_FETCH;
         cnt_reg   <= 4'd0;
         fault_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         fault_reg <= fault_next;
      end
   end

   // Reset masks every output, so an abandoned instruction cannot leak a write.
   assign ir_ena      = ir_ena_c      & ~rst;
   assign pc_inc      = pc_inc_c      & ~rst;
   assign pc_load     = pc_load_c     & ~rst;
   assign addr_sel    = addr_sel_c    & ~rst;
   assign mem_req     = mem_req_c     & ~rst;
   assign mem_we      = mem_we_c      & ~rst;
   assign alu_op      = rst ? 3'd0 : alu_op_c;
   assign alu_src_imm = alu_src_imm_c & ~rst;
   assign rf_we       = rf_we_c       & ~rst;
   assign wb_sel      = wb_sel_c      & ~rst;
   assign halted      = halted_c      & ~rst;
   assign fault       = fault_reg     & ~rst;

endmodule

// File: tb/tb_ir_control_fsm.sv
// Self-checking bench: a per-instruction phase model expands each instruction into
// expected per-cycle output vectors, which are replayed against the DUT.
module tb_ir_control_fsm;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst, alu_zero, mem_ready;
   logic [3:0] opcode;
   logic       ir_ena, pc_inc, pc_load, addr_sel, mem_req, mem_we;
   logic [2:0] alu_op;
   logic       alu_src_imm, rf_we, wb_sel, halted, fault;

   always #5 clk = ~clk;

   ir_control_fsm #(.MEM_TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .ir_ena(ir_ena), .pc_inc(pc_inc), .pc_load(pc_load), .addr_sel(addr_sel),
      .mem_req(mem_req), .mem_we(mem_we), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
      .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted), .fault(fault)
   );

   wire [13:0] obs = {ir_ena, pc_inc, pc_load, addr_sel, mem_req, mem_we,
                      alu_op, alu_src_imm, rf_we, wb_sel, halted, fault};

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        rst;
      logic        rdy;
      logic [3:0]  op;
      logic        z;
      logic [13:0] out;
   } cyc_t;

   cyc_t exp_q[$];

   function automatic logic [13:0] mk(input logic ir, input logic pci, input logic pcl,
                                      input logic asel, input logic mreq, input logic mwe,
                                      input logic [2:0] aop, input logic imm, input logic rfwe,
                                      input logic wbs, input logic hlt, input logic flt);
      return {ir, pci, pcl, asel, mreq, mwe, aop, imm, rfwe, wbs, hlt, flt};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [3:0] rop();
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic push(input logic r, input logic rdy, input logic [3:0] op,
                       input logic z, input logic [13:0] o);
      cyc_t c;
      c.rst = r; c.rdy = rdy; c.op = op; c.z = z; c.out = o;
      exp_q.push_back(c);
   endtask

   task automatic push_halt(input int n, input logic flt);
      repeat (n) push(1'b0, rb(), rop(), rb(), mk(0,0,0,0,0,0,3'd0,0,0,0,1,flt));
   endtask

   task automatic push_reset(input int n);
      repeat (n) push(1'b1, rb(), rop(), rb(), 14'd0);
   endtask

   // Expand one instruction into its cycle-by-cycle expectations. fw/mw are the
   // number of not-ready cycles before memory answers in FETCH/MEM; a wait of
   // TIMEOUT or more ends in HALT with the fault flag after TIMEOUT idle cycles.
   task automatic build(input logic [3:0] op, input logic z, input int fw,
                        input int mw, input int tail);
      logic is_r, is_mem, is_st, is_ld;
      logic [13:0] ex;
      is_r   = (op <= 4'd4);
      is_st  = (op == 4'd7);
      is_ld  = (op == 4'd6);
      is_mem = is_st || is_ld;
      for (int i = 0; i < ((fw >= TIMEOUT) ? TIMEOUT : fw); i++)
         push(1'b0, 1'b0, rop(), rb(), mk(0,0,0,0,1,0,3'd0,0,0,0,0,0));
      if (fw >= TIMEOUT) begin
         push_halt(tail, 1'b1);
         return;
      end
      push(1'b0, 1'b1, rop(), rb(), mk(1,1,0,0,1,0,3'd0,0,0,0,0,0));
      push(1'b0, rb(), op, rb(), 14'd0);
      if (op == 4'hF) begin
         push_halt(tail, 1'b0);
         return;
      end
      if (op >= 4'hA) return;
      if (is_r)            ex = mk(0,0,0,0,0,0,op[2:0],0,0,0,0,0);
      else if (op == 4'd8) ex = mk(0,0,z,0,0,0,3'd1,0,0,0,0,0);
      else if (op == 4'd9) ex = mk(0,0,1,0,0,0,3'd5,1,0,0,0,0);
      else                 ex = mk(0,0,0,0,0,0,3'd0,1,0,0,0,0);
      push(1'b0, rb(), op, z, ex);
      if (is_mem) begin
         for (int i = 0; i < ((mw >= TIMEOUT) ? TIMEOUT : mw); i++)
            push(1'b0, 1'b0, op, rb(), mk(0,0,0,1,1,is_st,3'd0,0,0,0,0,0));
         if (mw >= TIMEOUT) begin
            push_halt(tail, 1'b1);
            return;
         end
         push(1'b0, 1'b1, op, rb(), mk(0,0,0,1,1,is_st,3'd0,0,0,0,0,0));
      end
      if (is_r || op == 4'd5 || is_ld)
         push(1'b0, rb(), op, rb(), mk(0,0,0,0,0,0,3'd0,0,1,is_ld,0,0));
   endtask

   task automatic apply(input cyc_t c);
      @(negedge clk);
      rst       = c.rst;
      mem_ready = c.rdy;
      opcode    = c.op;
      alu_zero  = c.z;
      #1;
   endtask

   task automatic test_reset();
      cyc_t c;
      exp_q.delete();
      push_reset(3);
      while (exp_q.size() != 0) begin
         c = exp_q.pop_front();
         apply(c);
         checks++;
         if (obs !== c.out) begin
            errors++;
            $display("FAIL reset_outputs: got=%b want=%b", obs, c.out);
         end
      end
      $display("reset: 3 cycles held");
   endtask

   task automatic test_rtype();
      cyc_t c;
      for (int op = 0; op <= 5; op++) begin
         exp_q.delete();
         build(4'(op), rb(), (op == 0) ? 0 : $urandom_range(0, 2), 0, 0);
         build(4'hB, rb(), 1, 0, 0);
         while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            apply(c);
            checks++;
            if (obs !== c.out) begin
               errors++;
               $display("FAIL rtype_op%0d: got=%b want=%b", op, obs, c.out);
            end
         end
         $display("rtype: op=%0d then nop", op);
      end
   endtask

   task automatic test_load_wait();
      cyc_t c;
      exp_q.delete();
      build(4'd6, rb(), 0, 3, 0);
      build(4'd6, rb(), 2, 0, 0);
      while (exp_q.size() != 0) begin
         c = exp_q.pop_front();
         apply(c);
         checks++;
         if (obs !== c.out) begin
            errors++;
            $display("FAIL load_wait: got=%b want=%b", obs, c.out);
         end
      end
      $display("load: mem waits 3 then 0");
   endtask

   task automatic test_branch();
      cyc_t c;
      exp_q.delete();
      build(4'd8, 1'b1, 0, 0, 0);
      build(4'd8, 1'b0, 0, 0, 0);
      build(4'd9, rb(), 1, 0, 0);
      while (exp_q.size() != 0) begin
         c = exp_q.pop_front();
         apply(c);
         checks++;
         if (obs !== c.out) begin
            errors++;
            $display("FAIL branch: op=%h got=%b want=%b", c.op, obs, c.out);
         end
      end
      $display("branch: beq taken, beq not taken, jmp");
   endtask

   task automatic test_halt();
      cyc_t c;
      exp_q.delete();
      build(4'hF, rb(), 0, 0, 20);
      push_reset(1);
      build(4'd0, rb(), 1, 0, 0);
      while (exp_q.size() != 0) begin
         c = exp_q.pop_front();
         apply(c);
         checks++;
         if (obs !== c.out) begin
            errors++;
            $display("FAIL halt: got=%b want=%b", obs, c.out);
         end
      end
      $display("halt: 20 static cycles, reset, add");
   endtask

   task automatic test_timeout();
      cyc_t c;
      exp_q.delete();
      build(rop(), rb(), TIMEOUT, 0, 3);
      push_reset(2);
      build(4'd0, rb(), TIMEOUT - 1, 0, 0);
      build(4'd6, rb(), 0, TIMEOUT, 3);
      push_reset(2);
      build(4'd7, rb(), 0, TIMEOUT - 1, 0);
      while (exp_q.size() != 0) begin
         c = exp_q.pop_front();
         apply(c);
         checks++;
         if (obs !== c.out) begin
            errors++;
            $display("FAIL timeout: got=%b want=%b", obs, c.out);
         end
      end
      $display("timeout: fetch/mem at limit and one short of limit");
   endtask

   task automatic test_reset_mid_store();
      cyc_t c;
      exp_q.delete();
      build(4'd7, rb(), 0, 3, 0);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      push_reset(1);
      build(4'd1, rb(), 1, 0, 0);
      while (exp_q.size() != 0) begin
         c = exp_q.pop_front();
         apply(c);
         checks++;
         if (obs !== c.out) begin
            errors++;
            $display("FAIL reset_mid_store: rst=%b got=%b want=%b", c.rst, obs, c.out);
         end
      end
      $display("store: reset during MEM, then sub");
   endtask

   task automatic test_back_to_back();
      cyc_t c;
      logic [3:0] op;
      for (int n = 0; n < 40; n++) begin
         exp_q.delete();
         op = 4'($urandom_range(0, 14));
         build(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3), 0);
         while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            apply(c);
            checks++;
            if (obs !== c.out) begin
               errors++;
               $display("FAIL back_to_back: op=%h got=%b want=%b", op, obs, c.out);
            end
            checks++;
            if ((pc_inc && pc_load) || (rf_we && mem_we)) begin
               errors++;
               $display("FAIL exclusivity: pc_inc=%b pc_load=%b rf_we=%b mem_we=%b",
                        pc_inc, pc_load, rf_we, mem_we);
            end
         end
         $display("random: instr %0d op=%h", n, op);
      end
   endtask

   initial begin
      rst       = 1'b1;
      opcode    = 4'd0;
      alu_zero  = 1'b0;
      mem_ready = 1'b0;
      test_reset();
      test_rtype();
      test_load_wait();
      test_branch();
      test_halt();
      test_timeout();
      test_reset_mid_store();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ir_control_fsm.md
Name: ir_control_fsm

Overview:
- Multi-cycle control unit for the 16-bit CPU. Sequences instruction fetch into the instruction register, decode, execute, memory access and register write-back.
- Consumes the 4-bit opcode field from the IR field splitter, the ALU zero flag and a memory-ready handshake.
- Drives the IR load enable, PC controls, ALU/regfile/memory control strobes and a halted status.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles for mem_ready before the fault flag is raised; 4-bit counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  4  IR bits [15:12] from the field splitter
- alu_zero  in  1  ALU zero flag, valid in EXECUTE
- mem_ready  in  1  memory completes the current request this cycle
- ir_ena  out  1  load IR from the instruction bus
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= branch/jump target
- addr_sel  out  1  0 = PC drives memory address, 1 = ALU result drives it
- mem_req  out  1  memory request valid
- mem_we  out  1  write strobe, qualified by mem_req
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B
- alu_src_imm  out  1  ALU B operand = zero-extended imm[5:0]
- rf_we  out  1  register file write to rd
- wb_sel  out  1  0 = ALU result, 1 = memory data
- halted  out  1  HALT state reached
- fault  out  1  sticky, set on memory timeout

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. State is registered; outputs are combinational from state, opcode, alu_zero and mem_ready.
- Reset: when rst=1 at a clk edge, state <= FETCH, timeout counter <= 0, fault <= 0.
  - While rst is high, all outputs are forced to 0.
  - Reset mid-operation abandons the instruction; no rf_we or mem_we is asserted in the cycles rst is held.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR (R-type); 5 ADDI; 6 LOAD; 7 STORE; 8 BEQ; 9 JMP; F HALT. Codes A-E are NOP.
- FETCH:
  - Outputs: mem_req=1, addr_sel=0, mem_we=0.
  - On mem_ready=1: ir_ena=1 and pc_inc=1 in the same cycle, next state DECODE.
  - Otherwise stay in FETCH and increment the timeout counter.
- DECODE: one cycle, no strobes (register file read settles). Next state:
  - HALT if opcode=F
  - FETCH if NOP
  - else EXEC
- EXEC: alu_op and alu_src_imm are driven by opcode.
  - R-type: alu_op = opcode[2:0], alu_src_imm=0. Next WB.
  - ADDI: ADD with alu_src_imm=1. Next WB.
  - LOAD/STORE: ADD with alu_src_imm=1 (address = rs1 + imm). Next MEM.
  - BEQ: SUB with alu_src_imm=0. pc_load = alu_zero in this cycle. Next FETCH.
  - JMP: PASS_B with alu_src_imm=1, pc_load=1. Next FETCH.
- MEM:
  - Outputs: mem_req=1, addr_sel=1, mem_we = (opcode==7).
  - On mem_ready: LOAD goes to WB, STORE goes to FETCH.
  - Otherwise wait and count.
- WB:
  - rf_we=1 for one cycle; wb_sel = 1 for LOAD, else 0.
  - Next FETCH.
- HALT: absorbing state, halted=1, all other strobes 0. Only rst exits.
- Timeout:
  - The counter clears on every state change.
  - If the counter reaches MEM_TIMEOUT while waiting in FETCH or MEM: fault <= 1 (sticky until rst), next state HALT.
  - mem_ready arriving in the same cycle the counter hits the limit takes priority: the transfer completes and no fault is raised.
- Latency (zero-wait memory):
  - R-type/ADDI: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BEQ/JMP: 3 cycles
  - NOP: 2 cycles
- Exclusivity:
  - pc_inc and pc_load are never both 1.
  - rf_we and mem_we are never both 1.
  - opcode is sampled only in DECODE, EXEC, MEM and WB, when the IR is stable.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (OP_ADD..OP_HALT)
  - alu_op encodings
  - state enum
- Sub-module ctrl_decode: combinational opcode-to-{alu_op, alu_src_imm, is_mem, is_store, is_branch, is_jmp, writes_rd} lookup.
- The FSM, timeout counter and output muxing stay in ir_control_fsm.

Test Plan:
1. Reset then ADD (opcode 0), mem_ready=1 always -> ir_ena+pc_inc at cycle 1; EXEC alu_op=0; rf_we=1 wb_sel=0 at cycle 4; FETCH at cycle 5.
2. LOAD (6) with mem_ready delayed 3 cycles in MEM -> mem_req=1 addr_sel=1 mem_we=0 held 4 cycles; then WB with rf_we=1 wb_sel=1; total 8 cycles.
3. BEQ (8) with alu_zero=1, then BEQ with alu_zero=0 -> pc_load=1 in EXEC, then pc_load=0; pc_inc only in FETCH; rf_we never asserted.
4. HALT (F) -> halted=1 from cycle 3 onward, outputs stay static for 20 cycles; rst=1 returns to FETCH with halted=0.
5. mem_ready held 0 in FETCH -> fault=1 and halted=1 after MEM_TIMEOUT (15) wait cycles; also check mem_ready=1 on the limit cycle gives no fault.
6. STORE (7) with rst asserted during MEM -> mem_we drops to 0 during the rst cycle; next state FETCH; fault=0; no rf_we.
